// File: rtl/instr_fetch_if.sv
// instr_fetch_if: memory request/response, redirect and decode-side signals of the fetch unit
interface instr_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_fault;
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, fetch_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, fetch_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: in-order fetch with 2-entry buffer, redirect flush and stale-response dropping.
// Define IFETCH_MISALIGN_CHK_EN to enable the sticky misaligned-redirect fault.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);
  localparam logic [31:0] STEP = 32'(PC_STEP);
  logic [31:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, tgt;
  logic [31:0] buf_pc_q [2];
  logic [31:0] buf_instr_q [2];
  logic [1:0]  buf_cnt_q, buf_cnt_d, live_q, live_d, drop_q, drop_d, live_nx, drop_nx;
  logic        head_q, head_d, fault_q, fault_d, mis, tail;
  logic        req_v, req_hs, pop, push, rsp_live, rsp_drop;
`ifdef IFETCH_MISALIGN_CHK_EN
  assign tgt = bus.redirect_pc;
  assign mis = |bus.redirect_pc[1:0];
  assign bus.fetch_fault = fault_q;
`else
  assign tgt = bus.redirect_pc & ~32'h3;
  assign mis = 1'b0;
  assign bus.fetch_fault = 1'b0;
`endif
  assign bus.imem_req_valid = req_v;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.out_valid      = buf_cnt_q != 2'd0;
  assign bus.out_pc         = buf_pc_q[head_q];
  assign bus.out_instr      = buf_instr_q[head_q];
  // a slot freed by this cycle's pop counts as space, keeping 1/cycle throughput
  always_comb begin
    pop       = bus.out_valid && bus.out_ready;
    req_v     = !rst && !bus.redirect_valid && !fault_q &&
                (3'(buf_cnt_q) + 3'(live_q) - 3'(pop) < 3'd2) &&
                (3'(live_q) + 3'(drop_q) < 3'd2);
    req_hs    = req_v && bus.imem_req_ready;
    rsp_drop  = bus.imem_rsp_valid && drop_q != 2'd0;
    rsp_live  = bus.imem_rsp_valid && drop_q == 2'd0;
    push      = rsp_live && !bus.redirect_valid;
    tail      = head_q ^ buf_cnt_q[0];
    live_nx   = live_q + 2'(req_hs) - 2'(rsp_live);
    drop_nx   = drop_q - 2'(rsp_drop);
    live_d    = bus.redirect_valid ? 2'd0 : live_nx;
    drop_d    = bus.redirect_valid ? drop_nx + live_nx : drop_nx;
    buf_cnt_d = bus.redirect_valid ? 2'd0 : buf_cnt_q + 2'(push) - 2'(pop);
    head_d    = head_q ^ pop;
    fetch_pc_d = bus.redirect_valid ? tgt : fetch_pc_q + (req_hs ? STEP : 32'd0);
    rsp_pc_d  = bus.redirect_valid ? tgt : rsp_pc_q + (push ? STEP : 32'd0);
    fault_d   = fault_q || (bus.redirect_valid && mis);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      buf_cnt_q  <= 2'd0;
      live_q     <= 2'd0;
      drop_q     <= 2'd0;
      head_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      buf_cnt_q  <= buf_cnt_d;
      live_q     <= live_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      fault_q    <= fault_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[tail]    <= rsp_pc_q;
      buf_instr_q[tail] <= bus.imem_rsp_data;
    end
  end
endmodule
